// File: rtl/data_trans_packer.sv
// Repacks a mixed byte/nibble input stream into a byte-wide output stream.
// Nibbles are joined in arrival order: the earlier one goes in the low half.
module data_trans_packer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       byt,
  output logic [7:0] data_o,
  output logic       data_en
);

  typedef enum logic {
    IDLE,
    S_4BIT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] nib_q, nib_d;
  logic [7:0] data_o_q, data_o_d;
  logic       data_en_q, data_en_d;

  // reset_n is active-high despite its name
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q   <= IDLE;
      nib_q     <= 4'h0;
      data_o_q  <= 8'h00;
      data_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nib_q     <= nib_d;
      data_o_q  <= data_o_d;
      data_en_q <= data_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    nib_d     = nib_q;
    data_o_d  = data_o_q;
    data_en_d = 1'b0;

    if (start) begin
      unique case (state_q)
        IDLE: begin
          if (byt) begin
            data_o_d  = data_in;
            data_en_d = 1'b1;
          end else begin
            nib_d   = data_in[3:0];
            state_d = S_4BIT;
          end
        end
        S_4BIT: begin
          // A full byte here splits: its low nibble completes the pending
          // byte and its high nibble becomes the new pending nibble.
          data_o_d  = {data_in[3:0], nib_q};
          data_en_d = 1'b1;
          if (byt) begin
            nib_d = data_in[7:4];
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_o  = data_o_q;
  assign data_en = data_en_q;

endmodule

// File: tb/tb_data_trans_packer.sv
// Self-checking bench for data_trans_packer: directed scenarios followed by
// random traffic, compared against a nibble-queue reference model.
module tb_data_trans_packer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] data_in;
  logic       byt;
  logic [7:0] data_o;
  logic       data_en;

  int         checkCount;
  int         passCount;

  logic [3:0] nibQueue[$];
  logic [7:0] expData;
  logic       expEn;

  data_trans_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .data_in (data_in),
    .byt     (byt),
    .data_o  (data_o),
    .data_en (data_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %02h expected %02h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: every consumed input appends its nibbles to a queue,
  // and any two queued nibbles leave as one byte, earlier nibble low.
  task automatic modelStep(input logic s, input logic [7:0] d, input logic b);
    logic [3:0] lo, hi;
    expEn = 1'b0;
    if (s) begin
      nibQueue.push_back(d[3:0]);
      if (b) nibQueue.push_back(d[7:4]);
      if (nibQueue.size() >= 2) begin
        lo      = nibQueue.pop_front();
        hi      = nibQueue.pop_front();
        expData = {hi, lo};
        expEn   = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] d, input logic b);
    @(negedge clk);
    start   = s;
    data_in = d;
    byt     = b;
    modelStep(s, d, b);
    @(posedge clk);
    #1;
    checkOutput("data_en", {7'd0, data_en}, {7'd0, expEn});
    checkOutput("data_o", data_o, expData);
  endtask

  task automatic applyReset(input int cycles);
    @(negedge clk);
    reset_n = 1'b1;
    start   = 1'b0;
    nibQueue.delete();
    expData = 8'h00;
    expEn   = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    checkOutput("reset_en", {7'd0, data_en}, 8'h00);
    checkOutput("reset_data", data_o, 8'h00);
    @(negedge clk);
    reset_n = 1'b0;
  endtask

  // Nibble-only input with random junk in the unused upper bits.
  function automatic logic [7:0] nibIn(input logic [3:0] n);
    logic [3:0] junk;
    junk = 4'($urandom);
    return {junk, n};
  endfunction

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset_n    = 1'b1;
    start      = 1'b0;
    data_in    = 8'h00;
    byt        = 1'b0;
    expData    = 8'h00;
    expEn      = 1'b0;

    $display("[TB] reset");
    applyReset(4);

    $display("[TB] reset while a nibble is pending");
    applyStimulus(1'b1, nibIn(4'hC), 1'b0);
    applyReset(2);
    applyStimulus(1'b1, 8'h5A, 1'b1);
    checkOutput("post_reset_byte", data_o, 8'h5A);

    $display("[TB] mixed stream");
    applyStimulus(1'b1, 8'h10, 1'b1);
    checkOutput("mix0", data_o, 8'h10);
    applyStimulus(1'b1, nibIn(4'h2), 1'b0);
    checkOutput("mix1_en", {7'd0, data_en}, 8'h00);
    applyStimulus(1'b1, 8'h43, 1'b1);
    checkOutput("mix2", data_o, 8'h32);
    applyStimulus(1'b1, 8'h95, 1'b1);
    checkOutput("mix3", data_o, 8'h54);
    applyStimulus(1'b1, nibIn(4'h6), 1'b0);
    checkOutput("mix4", data_o, 8'h69);
    applyStimulus(1'b1, 8'h87, 1'b1);
    checkOutput("mix5", data_o, 8'h87);

    $display("[TB] all-byte stream");
    applyStimulus(1'b1, 8'hA5, 1'b1);
    checkOutput("byte0", data_o, 8'hA5);
    applyStimulus(1'b1, 8'h3C, 1'b1);
    checkOutput("byte1", data_o, 8'h3C);

    $display("[TB] nibble pair");
    applyStimulus(1'b1, nibIn(4'hF), 1'b0);
    applyStimulus(1'b1, nibIn(4'h1), 1'b0);
    checkOutput("pair", data_o, 8'h1F);

    $display("[TB] start gating");
    applyStimulus(1'b1, nibIn(4'h7), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'($urandom), 1'($urandom));
    applyStimulus(1'b1, nibIn(4'h2), 1'b0);
    checkOutput("gated", data_o, 8'h27);

    $display("[TB] odd carry chain");
    applyStimulus(1'b1, nibIn(4'h1), 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b1);
    checkOutput("carry0", data_o, 8'h21);
    applyStimulus(1'b1, 8'h54, 1'b1);
    checkOutput("carry1", data_o, 8'h43);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, nibIn(4'hE), 1'b0);
    checkOutput("carry_flush", data_o, 8'hE5);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic s, b;
      s = ($urandom_range(0, 3) != 0);
      b = 1'($urandom);
      applyStimulus(s, b ? 8'($urandom) : nibIn(4'($urandom)), b);
      if (i == 200) applyReset(1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
